// File: rtl/csr_access_unit.sv
// Zicsr initiator: runs one CSRRW/S/C(I) as a sequenced read-modify-write against the CSR file
// and returns the old value (or an illegal flag) on a valid/ready response channel.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [CSR_AW-1:0] req_csr_addr_i,
  input  logic [XLEN-1:0]   req_rs1_data_i,
  input  logic [4:0]        req_rs1_idx_i,
  input  logic [4:0]        req_rd_idx_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rd_data_o,
  output logic [4:0]        rsp_rd_idx_o,
  output logic              rsp_illegal_o,
  output logic              csr_read_enable_o,
  output logic              csr_write_enable_o,
  output logic [CSR_AW-1:0] csr_address_o,
  output logic [XLEN-1:0]   csr_write_data_o,
  input  logic [XLEN-1:0]   csr_read_data_i
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        f3_q;
  logic [CSR_AW-1:0] addr_q;
  logic [XLEN-1:0]   rs1_q, old_q;
  logic [4:0]        rs1_idx_q, rd_q;
  logic              illegal_q, illegal_d;
  logic              rdy_q, rd_en_q, wr_en_q, rsp_v_q;
  logic [CSR_AW-1:0] caddr_q;
  logic [XLEN-1:0]   cwdata_q, wdata_d;
  logic              accept, wr_intent;

  function automatic logic [XLEN-1:0] operand(input logic [2:0] f3, input logic [XLEN-1:0] rs1,
                                              input logic [4:0] idx);
    return f3[2] ? {{(XLEN-5){1'b0}}, idx} : rs1;
  endfunction

  function automatic logic [XLEN-1:0] apply(input logic [2:0] f3, input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] op);
    case (f3[1:0])
      2'b01:   return op;
      2'b10:   return old | op;
      default: return old & ~op;
    endcase
  endfunction

  assign accept    = req_valid_i & rdy_q;
  // S/C forms with a zero rs1 field are pure reads and may target read-only CSRs
  assign wr_intent = (req_funct3_i[1:0] == 2'b01) || (req_rs1_idx_i != 5'd0);

  always_comb begin
    state_d   = state_q;
    wdata_d   = '0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if ((req_funct3_i[1:0] == 2'b00) ||
            (wr_intent && req_csr_addr_i[CSR_AW-1 -: 2] == 2'b11)) begin
          illegal_d = 1'b1;
          state_d   = RESP;
        end else if (req_funct3_i[1:0] == 2'b01 && req_rd_idx_i == 5'd0) begin
          state_d = WRITE;
          wdata_d = operand(req_funct3_i, req_rs1_data_i, req_rs1_idx_i);
        end else begin
          state_d = READ;
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        if (f3_q[1:0] != 2'b01 && rs1_idx_q == 5'd0) begin
          state_d = RESP;
        end else begin
          state_d = WRITE;
          wdata_d = apply(f3_q, csr_read_data_i, operand(f3_q, rs1_q, rs1_idx_q));
        end
      end
      WRITE: state_d = RESP;
      RESP:  if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      addr_q    <= '0;
      rs1_q     <= '0;
      rs1_idx_q <= '0;
      rd_q      <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
      rdy_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rsp_v_q   <= 1'b0;
      caddr_q   <= '0;
      cwdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= (state_d == IDLE);
      rd_en_q  <= (state_d == READ);
      wr_en_q  <= (state_d == WRITE);
      rsp_v_q  <= (state_d == RESP);
      caddr_q  <= (state_d == READ || state_d == WRITE) ? (accept ? req_csr_addr_i : addr_q) : '0;
      cwdata_q <= wdata_d;
      if (accept) begin
        f3_q      <= req_funct3_i;
        addr_q    <= req_csr_addr_i;
        rs1_q     <= req_rs1_data_i;
        rs1_idx_q <= req_rs1_idx_i;
        rd_q      <= req_rd_idx_i;
        old_q     <= '0;
        illegal_q <= illegal_d;
      end
      if (state_q == CAPT) old_q <= csr_read_data_i;
    end
  end

  assign req_ready_o        = rdy_q;
  assign csr_read_enable_o  = rd_en_q;
  assign csr_write_enable_o = wr_en_q;
  assign csr_address_o      = caddr_q;
  assign csr_write_data_o   = cwdata_q;
  assign rsp_valid_o        = rsp_v_q;
  assign rsp_rd_data_o      = rsp_v_q ? old_q : '0;
  assign rsp_rd_idx_o       = rsp_v_q ? rd_q : '0;
  assign rsp_illegal_o      = rsp_v_q & illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized bench for csr_access_unit: behavioural CSR file + transaction-level reference model,
// compared against the DUT every falling edge, plus hand-computed directed cases.
module tb_csr_access_unit;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, rsp_illegal_o;
  logic [2:0]  req_funct3_i;
  logic [11:0] req_csr_addr_i, csr_address_o;
  logic [31:0] req_rs1_data_i, rsp_rd_data_o, csr_write_data_o, csr_read_data_i;
  logic [4:0]  req_rs1_idx_i, req_rd_idx_i, rsp_rd_idx_o;
  logic        csr_read_enable_o, csr_write_enable_o;

  always #5 clk_i = ~clk_i;

  csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_funct3_i(req_funct3_i),
    .req_csr_addr_i(req_csr_addr_i), .req_rs1_data_i(req_rs1_data_i),
    .req_rs1_idx_i(req_rs1_idx_i), .req_rd_idx_i(req_rd_idx_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rd_data_o(rsp_rd_data_o),
    .rsp_rd_idx_o(rsp_rd_idx_o), .rsp_illegal_o(rsp_illegal_o),
    .csr_read_enable_o(csr_read_enable_o), .csr_write_enable_o(csr_write_enable_o),
    .csr_address_o(csr_address_o), .csr_write_data_o(csr_write_data_o),
    .csr_read_data_i(csr_read_data_i)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // CSR register file: registered read data, backdoor preload port
  logic [31:0] csr_mem [4096];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_strobes = 0, rd_strobes = 0;
  always @(posedge clk_i) begin
    if (bd_we) csr_mem[bd_addr] <= bd_data;
    if (csr_write_enable_o) begin
      csr_mem[csr_address_o] <= csr_write_data_o;
      wr_strobes <= wr_strobes + 1;
    end
    if (csr_read_enable_o) begin
      csr_read_data_i <= csr_mem[csr_address_o];
      rd_strobes <= rd_strobes + 1;
    end
  end

  // Reference model: per transaction, which cycle after accept each event is due
  logic [31:0] ref_mem [4096];
  bit          m_busy = 0, m_ready = 0, m_ill, wr;
  int          m_k, m_rd_at, m_wr_at, m_rsp_at;
  logic [11:0] m_addr;
  logic [31:0] m_new, m_data, opnd;
  logic [4:0]  m_rd;
  logic [1:0]  op;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy = 0; m_ready = 0;
    end else begin
      if (bd_we) ref_mem[bd_addr] = bd_data;
      if (m_busy) begin
        if (m_k >= m_rsp_at && rsp_ready_i) m_busy = 0;
        else begin
          m_k++;
          if (m_k == m_wr_at) ref_mem[m_addr] = m_new;
        end
      end else if (m_ready && req_valid_i) begin
        op = req_funct3_i[1:0];
        m_addr = req_csr_addr_i; m_rd = req_rd_idx_i;
        m_ill = 0; m_rd_at = 0; m_wr_at = 0; m_data = 0; m_new = 0;
        opnd = req_funct3_i[2] ? {27'b0, req_rs1_idx_i} : req_rs1_data_i;
        wr = (op == 2'd1) || (req_rs1_idx_i != 0);
        if (op == 2'd0 || (wr && req_csr_addr_i[11:10] == 2'b11)) begin
          m_ill = 1; m_rsp_at = 1;
        end else if (op == 2'd1 && req_rd_idx_i == 0) begin
          m_wr_at = 1; m_rsp_at = 2; m_new = opnd;
        end else begin
          m_rd_at = 1; m_data = ref_mem[req_csr_addr_i];
          m_wr_at = wr ? 3 : 0; m_rsp_at = wr ? 4 : 3;
          case (op)
            2'd1:    m_new = opnd;
            2'd2:    m_new = m_data | opnd;
            default: m_new = m_data & ~opnd;
          endcase
        end
        m_busy = 1; m_k = 1;
        if (m_wr_at == 1) ref_mem[m_addr] = m_new;
      end
      m_ready = !m_busy;
    end
  end

  bit e_rs, e_ws, e_rv;
  always @(negedge clk_i) begin
    e_rs = m_busy && m_k == m_rd_at;
    e_ws = m_busy && m_k == m_wr_at;
    e_rv = m_busy && m_k >= m_rsp_at;
    chk("req_ready", req_ready_o, m_ready);
    chk("rd_strobe", csr_read_enable_o, e_rs);
    chk("wr_strobe", csr_write_enable_o, e_ws);
    chk("csr_addr", csr_address_o, (e_rs || e_ws) ? m_addr : 12'h0);
    chk("csr_wdata", csr_write_data_o, e_ws ? m_new : 32'h0);
    chk("rsp_valid", rsp_valid_o, e_rv);
    if (e_rv) begin
      chk("rsp_data", rsp_rd_data_o, m_data);
      chk("rsp_idx", rsp_rd_idx_o, m_rd);
      chk("rsp_illegal", rsp_illegal_o, m_ill);
    end
    if (rst_i) chk("rst_rsp_fields", {rsp_rd_data_o, rsp_rd_idx_o, rsp_illegal_o}, 0);
  end

  task automatic setcsr(input logic [11:0] a, input logic [31:0] v);
    bd_we = 1; bd_addr = a; bd_data = v;
    @(posedge clk_i); #1;
    bd_we = 0;
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d1,
                        input logic [4:0] i1, input logic [4:0] rd, input int hold,
                        output logic [31:0] data, output int lat, output logic ill,
                        output logic [4:0] idx);
    int n = 0;
    req_valid_i = 1; req_funct3_i = f3; req_csr_addr_i = a;
    req_rs1_data_i = d1; req_rs1_idx_i = i1; req_rd_idx_i = rd;
    while (!req_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n >= 50) begin checks++; failures++; $display("FAIL accept_timeout: ready never rose"); end
    @(posedge clk_i); #1;
    req_valid_i = 0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
    if (!rsp_valid_o) begin checks++; failures++; $display("FAIL rsp_timeout: no response"); end
    data = rsp_rd_data_o; ill = rsp_illegal_o; idx = rsp_rd_idx_o;
    repeat (hold) begin @(posedge clk_i); #1; end
    rsp_ready_i = 1;
    @(posedge clk_i); #1;
    rsp_ready_i = 0;
  endtask

  logic [11:0] addrs [8] = '{12'h300, 12'h305, 12'h341, 12'h340, 12'hC00, 12'hF11, 12'h7C0, 12'h800};
  logic [31:0] d;
  int          l, w0, r0;
  logic        il;
  logic [4:0]  ix;

  initial begin
    req_valid_i = 0; req_funct3_i = 0; req_csr_addr_i = 0; req_rs1_data_i = 0;
    req_rs1_idx_i = 0; req_rd_idx_i = 0; rsp_ready_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    chk("ready_before_edge", req_ready_o, 0);
    @(posedge clk_i); #1;
    chk("ready_first_edge", req_ready_o, 1);
    for (int i = 0; i < 8; i++) setcsr(addrs[i], $urandom);

    // 1: CSRRW full RMW
    setcsr(12'h300, 0);
    do_req(3'b001, 12'h300, 32'h1888, 5'd1, 5'd5, 0, d, l, il, ix);
    chk("t1_data", d, 0); chk("t1_idx", ix, 5); chk("t1_lat", l, 4);
    chk("t1_mem", csr_mem[12'h300], 32'h1888);
    // 2: CSRRS rs1=0 read only
    setcsr(12'h341, 32'h8000_0100); w0 = wr_strobes;
    do_req(3'b010, 12'h341, 32'hFFFF_FFFF, 5'd0, 5'd3, 0, d, l, il, ix);
    chk("t2_data", d, 32'h8000_0100); chk("t2_lat", l, 3); chk("t2_nowrite", wr_strobes - w0, 0);
    // 3: CSRRCI
    setcsr(12'h300, 32'h88);
    do_req(3'b111, 12'h300, 0, 5'd8, 5'd1, 0, d, l, il, ix);
    chk("t3_data", d, 32'h88); chk("t3_mem", csr_mem[12'h300], 32'h80);
    // 4: CSRRW rd=0, no read
    r0 = rd_strobes;
    do_req(3'b001, 12'h305, 32'h100, 5'd2, 5'd0, 0, d, l, il, ix);
    chk("t4_data", d, 0); chk("t4_noread", rd_strobes - r0, 0); chk("t4_mem", csr_mem[12'h305], 32'h100);
    // 5: illegal forms and read-only legal read
    r0 = rd_strobes; w0 = wr_strobes;
    do_req(3'b000, 12'h300, 0, 5'd1, 5'd1, 0, d, l, il, ix);
    chk("t5a_ill", il, 1); chk("t5a_lat", l, 1);
    do_req(3'b001, 12'hC00, 32'h5, 5'd1, 5'd1, 0, d, l, il, ix);
    chk("t5b_ill", il, 1); chk("t5_nostrobe", (rd_strobes - r0) + (wr_strobes - w0), 0);
    setcsr(12'hC00, 32'h1234_5678);
    do_req(3'b010, 12'hC00, 0, 5'd0, 5'd7, 0, d, l, il, ix);
    chk("t5c_ill", il, 0); chk("t5c_data", d, 32'h1234_5678);
    // 6: held response, then reset while the RMW is in flight
    do_req(3'b010, 12'h300, 32'h3, 5'd4, 5'd9, 3, d, l, il, ix);
    chk("t6_data", d, 32'h80);
    setcsr(12'h340, 32'h1234); w0 = wr_strobes;
    req_valid_i = 1; req_funct3_i = 3'b001; req_csr_addr_i = 12'h340;
    req_rs1_data_i = 32'hDEAD; req_rs1_idx_i = 1; req_rd_idx_i = 1;
    @(posedge clk_i); #1; req_valid_i = 0;
    @(posedge clk_i); #1; rst_i = 1; #1;
    chk("rst_outputs", {req_ready_o, rsp_valid_o, csr_read_enable_o, csr_write_enable_o,
                        csr_address_o, csr_write_data_o}, 0);
    @(posedge clk_i); #1; rst_i = 0;
    @(posedge clk_i); #1;
    chk("rst_nowrite", wr_strobes - w0, 0); chk("rst_mem", csr_mem[12'h340], 32'h1234);

    for (int i = 0; i < 250; i++) begin
      do_req(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 7)], $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
             $urandom_range(0, 2), d, l, il, ix);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    repeat (3) @(posedge clk_i);
    for (int i = 0; i < 8; i++) chk("final_mem", csr_mem[addrs[i]], ref_mem[addrs[i]]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
